// File: rtl/axis_video_tpg.sv
// AXI4-Stream RGB test pattern generator: colour bars, ramps and checkerboard,
// one pixel per beat with tuser on the first pixel of a frame and tlast at end of line.
module axis_video_tpg #(
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        aclken,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic [23:0] m_axis_video_tdata,
    output logic        m_axis_video_tvalid,
    input  logic        m_axis_video_tready,
    output logic        m_axis_video_tuser,
    output logic        m_axis_video_tlast,
    output logic        frame_done,
    output logic [15:0] frame_count
);
    localparam logic [11:0] X_LAST   = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_LAST   = 12'(V_ACTIVE - 1);
    localparam logic [11:0] SEG_LAST = 12'(H_ACTIVE / 8 - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state_r, state_s;
    logic [11:0] x_r, x_s, y_r, y_s, seg_r, seg_s;
    logic [2:0]  bar_r, bar_s;
    logic [1:0]  pat_r, pat_s;
    logic [7:0]  fcb_r, fcb_s;
    logic [23:0] tdata_r, tdata_s;
    logic        tvalid_r, tvalid_s, tuser_r, tuser_s, tlast_r, tlast_s;
    logic        done_r, done_s, load_s;
    logic [15:0] fcnt_r, fcnt_s;

    // Pixel value packed as {R, B, G}; colour bars indexed by bar number.
    function automatic logic [23:0] pixel(input logic [1:0] pat, input logic [11:0] x,
                                          input logic [11:0] y, input logic [2:0] bar,
                                          input logic [7:0] fcb);
        logic [23:0] px;
        logic [7:0]  v;
        v = x[7:0] + fcb;
        case (pat)
            2'd0: begin
                case (bar)
                    3'd0:    px = 24'hFFFFFF;
                    3'd1:    px = 24'hFF00FF;
                    3'd2:    px = 24'h00FFFF;
                    3'd3:    px = 24'h0000FF;
                    3'd4:    px = 24'hFFFF00;
                    3'd5:    px = 24'hFF0000;
                    3'd6:    px = 24'h00FF00;
                    default: px = 24'h000000;
                endcase
            end
            2'd1:    px = {x[7:0], x[7:0], x[7:0]};
            2'd2:    px = (x[3] ^ y[3]) ? 24'h000000 : 24'hFFFFFF;
            default: px = {v, v, v};
        endcase
        return px;
    endfunction

    // Next-state, position counters and next output beat.
    always_comb begin
        state_s = state_r;
        x_s     = x_r;
        y_s     = y_r;
        seg_s   = seg_r;
        bar_s   = bar_r;
        pat_s   = pat_r;
        fcb_s   = fcb_r;
        fcnt_s  = fcnt_r;
        done_s  = 1'b0;
        load_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_s = ACTIVE;
                    x_s     = 12'd0;
                    y_s     = 12'd0;
                    seg_s   = 12'd0;
                    bar_s   = 3'd0;
                    pat_s   = pattern_sel;
                    fcb_s   = fcnt_r[7:0];
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ACTIVE: begin
                if (tvalid_r && m_axis_video_tready) begin
                    if (x_r == X_LAST) begin
                        x_s   = 12'd0;
                        seg_s = 12'd0;
                        bar_s = 3'd0;
                        if (y_r == Y_LAST) begin
                            y_s    = 12'd0;
                            done_s = 1'b1;
                            fcnt_s = fcnt_r + 16'd1;
                            if (enable) begin
                                pat_s  = pattern_sel;
                                fcb_s  = fcnt_s[7:0];
                                load_s = 1'b1;
                            end else begin
                                state_s = IDLE;
                            end
                        end else begin
                            y_s    = y_r + 12'd1;
                            load_s = 1'b1;
                        end
                    end else begin
                        x_s    = x_r + 12'd1;
                        load_s = 1'b1;
                        if (seg_r == SEG_LAST) begin
                            seg_s = 12'd0;
                            bar_s = bar_r + 3'd1;
                        end else begin
                            seg_s = seg_r + 12'd1;
                        end
                    end
                end else begin
                    state_s = ACTIVE;
                end
            end
            default: state_s = IDLE;
        endcase

        tvalid_s = (state_s == ACTIVE);
        if (load_s) begin
            tdata_s = pixel(pat_s, x_s, y_s, bar_s, fcb_s);
            tuser_s = (x_s == 12'd0) && (y_s == 12'd0);
            tlast_s = (x_s == X_LAST);
        end else if (state_s == IDLE) begin
            tdata_s = tdata_r;
            tuser_s = 1'b0;
            tlast_s = 1'b0;
        end else begin
            tdata_s = tdata_r;
            tuser_s = tuser_r;
            tlast_s = tlast_r;
        end
    end

    // State and output registers; everything freezes while aclken is low.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r  <= IDLE;
            x_r      <= 12'd0;
            y_r      <= 12'd0;
            seg_r    <= 12'd0;
            bar_r    <= 3'd0;
            pat_r    <= 2'd0;
            fcb_r    <= 8'd0;
            tdata_r  <= 24'd0;
            tvalid_r <= 1'b0;
            tuser_r  <= 1'b0;
            tlast_r  <= 1'b0;
            done_r   <= 1'b0;
            fcnt_r   <= 16'd0;
        end else if (aclken) begin
            state_r  <= state_s;
            x_r      <= x_s;
            y_r      <= y_s;
            seg_r    <= seg_s;
            bar_r    <= bar_s;
            pat_r    <= pat_s;
            fcb_r    <= fcb_s;
            tdata_r  <= tdata_s;
            tvalid_r <= tvalid_s;
            tuser_r  <= tuser_s;
            tlast_r  <= tlast_s;
            done_r   <= done_s;
            fcnt_r   <= fcnt_s;
        end else begin
            state_r  <= state_r;
        end
    end

    assign m_axis_video_tdata  = tdata_r;
    assign m_axis_video_tvalid = tvalid_r;
    assign m_axis_video_tuser  = tuser_r;
    assign m_axis_video_tlast  = tlast_r;
    assign frame_done          = done_r;
    assign frame_count         = fcnt_r;
endmodule
